// File: rtl/paralelo_serie_tx.sv
// Transmit-side parallel-to-serial stage: MSB-first byte shifter with a post-reset COM sync burst and COM idle fill.
// Optional `define PS_DATA_COUNT_EN adds a 16-bit count of accepted data bytes on port data_cnt.
module paralelo_serie_tx #(
  parameter logic [7:0]  COM_BYTE      = 8'hBC,
  parameter int unsigned PRE_COM_COUNT = 4
) (
  input  logic        clk32f,
  input  logic        reset,
  input  logic [7:0]  in,
  input  logic        valid,
  output logic        ready,
  output logic        out,
  output logic        active
`ifdef PS_DATA_COUNT_EN
  ,
  output logic [15:0] data_cnt
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned COM_W  = 4;
  localparam logic [COM_W-1:0] COM_LAST = COM_W'(PRE_COM_COUNT - 1);

  typedef enum logic {SYNC, RUN} state_t;

  state_t             state, state_nxt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [COM_W-1:0]   com_cnt, com_cnt_nxt;
  logic [BYTE_W-1:0]  shreg;
  logic [BYTE_W-1:0]  byte_sel;
  logic               load;
  logic               accept;

  // Byte slot boundary: the edge that loads the next byte into the shifter.
  assign load     = (bit_cnt == BIT_W'(7));
  assign ready    = (state == RUN) && load;
  assign active   = (state == RUN);
  assign accept   = ready && valid;
  assign byte_sel = accept ? in : COM_BYTE;

  always_ff @(posedge clk32f) begin
    if (!reset) begin
      state   <= SYNC;
      com_cnt <= '0;
    end else begin
      state   <= state_nxt;
      com_cnt <= com_cnt_nxt;
    end
  end

  // Count sync COMs; leave SYNC on the load edge of the last one.
  always_comb begin
    state_nxt   = state;
    com_cnt_nxt = com_cnt;
    case (state)
      SYNC: begin
        if (load) begin
          com_cnt_nxt = com_cnt + COM_W'(1);
          if (com_cnt == COM_LAST) state_nxt = RUN;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = SYNC;
    endcase
  end

  always_ff @(posedge clk32f) begin
    if (!reset) begin
      bit_cnt <= BIT_W'(7);
      shreg   <= '0;
      out     <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + BIT_W'(1);
      if (load) begin
        out   <= byte_sel[BYTE_W-1];
        shreg <= {byte_sel[BYTE_W-2:0], 1'b0};
      end else begin
        out   <= shreg[BYTE_W-1];
        shreg <= {shreg[BYTE_W-2:0], 1'b0};
      end
    end
  end

`ifdef PS_DATA_COUNT_EN
  localparam int unsigned CNT_W = 16;

  always_ff @(posedge clk32f) begin
    if (!reset) begin
      data_cnt <= '0;
    end else if (accept) begin
      data_cnt <= data_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/paralelo_serie_tx.md
Name: paralelo_serie_tx

Overview:
- Transmit-side parallel-to-serial stage; sits directly upstream of the receive serial-to-parallel stage on the 1-bit lane.
- Accepts 8-bit bytes through a valid/ready handshake and shifts them out MSB-first, one bit per clk32f cycle.
- Emits a burst of COM (0xBC) bytes after reset so the receiver can lock, and fills idle slots with COM whenever no data is offered.

Parameters:
- COM_BYTE, 8'hBC, fill/sync symbol shifted out when no data byte is accepted.
- PRE_COM_COUNT, 4, number of COM bytes sent after reset before data is accepted; legal range 1..15.

Ports:
- clk32f  input  1  bit clock; the only clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk32f.
- in  input  8  parallel data byte.
- valid  input  1  high when `in` holds a byte to send.
- ready  output  1  high for exactly one cycle per byte slot when the block can take a byte.
- out  output  1  serial bit stream, registered.
- active  output  1  high once the post-reset COM burst is done (RUN state).

Behaviour:
- State:
  - 2-state FSM: SYNC, RUN.
  - 3-bit bit counter bit_cnt.
  - 4-bit com_cnt.
  - 8-bit shift register shreg.
- Reset (reset==0 at an edge):
  - Next state: state=SYNC, bit_cnt=7, com_cnt=0, shreg=0, out=0.
  - Outputs: ready=0, active=0.
  - Holds while reset stays low.
- bit_cnt increments by 1 every non-reset edge and wraps 7->0.
- A "load edge" is any non-reset edge with bit_cnt==7. The first edge after reset release is a load edge.
- Load edge:
  - Selected byte B = `in` if (ready && valid), else COM_BYTE.
  - out<=B[7]; shreg<={B[6:0],1'b0}.
- Non-load edge: out<=shreg[7]; shreg<=shreg<<1.
- Resulting bit timing:
  - Each byte occupies `out` for the 8 cycles after its load edge, MSB first.
  - There are no gaps between bytes.
- ready = (state==RUN) && (bit_cnt==7). It is combinational from registers only and does not depend on `valid`.
- Handshake:
  - A byte is accepted at the edge where ready && valid are both high.
  - `in` is sampled only at that edge.
  - valid high while ready is low is ignored; the byte is not queued.
  - There is no backpressure storage: valid dropped before ready means no transfer.
- SYNC state:
  - Every load edge loads COM_BYTE and increments com_cnt.
  - On the load edge where com_cnt==PRE_COM_COUNT-1, state<=RUN.
  - Effect: exactly PRE_COM_COUNT COMs are loaded in SYNC. ready first rises in the last cycle of the final sync COM, so the first data byte can directly follow it.
- RUN state: remains until reset. active=1 in RUN.
- Latency: a byte accepted at edge E has its MSB on `out` in the cycle after E and its LSB 7 cycles later.
- Reset mid-byte:
  - The in-flight byte is abandoned; `out` is 0 from the next edge.
  - The SYNC burst restarts after release.
- Simultaneous reset and handshake: reset wins and the byte is not accepted.

Optional Feature:
- Macro: PS_DATA_COUNT_EN.
- Defined:
  - Adds output port data_cnt [15:0].
  - Increments on every accepted byte (ready && valid at the edge); COM fill bytes are not counted.
  - Wraps 0xFFFF->0x0000.
  - Resets to 0 under reset.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Test Plan:
- Reset then release with valid=0 and PRE_COM_COUNT=4:
  - `out` carries 10111100 repeated continuously, starting the cycle after the first post-release edge.
  - active rises after the 4th COM load edge.
  - ready first pulses in cycle 32.
- After sync, hold valid=1 with in=8'hA5 then 8'h3C on successive ready pulses: `out` = 10100101 followed by 00111100, with no idle bits between bytes.
- Assert valid only on alternate ready slots with in=8'hFF: `out` alternates 11111111 and 10111100 (COM fill).
- valid=1 with in=8'h55 during a cycle where ready=0, dropped before ready: the byte is never transmitted; only COM appears on `out`.
- reset low for one edge in the middle of byte 8'hA5 (after 3 bits):
  - `out`=0 and ready=0 the next cycle.
  - After release, 4 COMs are sent before ready returns.
- With PS_DATA_COUNT_EN:
  - Send 3 data bytes interleaved with 2 COM fills: data_cnt=3.
  - Preload data_cnt near wrap and send 2 bytes: data_cnt goes 0xFFFF->0x0000->0x0001.
